path_stack: RTL and testbench

Stack datapath for the maze solver: stores the direction codes of the rat's current path as the solver pushes and pops moves, then replays the stored path bottom-to-top on request. It responds to the `write`/`read` strobes issued by the stack controller. It also answers the controller's show-path sequence: `rst_adr` starts the replay, and `finish` tells the controller that replay is complete.

---
 rtl/path_stack.sv | 142 ++++++++++++++
 tb/tb_path_stack.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/path_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | path_stack: LIFO of rat direction codes with bottom-to-top path replay.  |
// | Optional PATH_STACK_ERR_EN adds a sticky err output for dropped strobes. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module path_stack #(
  parameter int DATA_W = 2,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic              read,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  input  logic              rst_adr,
  output logic              move_valid,
  output logic [DATA_W-1:0] move_dir,
  input  logic              move_ready,
  output logic              finish
`ifdef PATH_STACK_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int             DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] C_ONE   = 1;
  localparam logic [1:0]     C_STACK  = 2'd0;
  localparam logic [1:0]     C_REPLAY = 2'd1;
  localparam logic [1:0]     C_DONE   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]   sp_q, sp_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   top_idx;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rst_adr_q;
  logic              push_en;
  logic              replay_req;

  assign top_idx  = sp_q - C_ONE;
  // sp never exceeds DEPTH, so its MSB alone marks a full stack
  assign full     = sp_q[ADDR_W];
  assign empty    = (sp_q == '0);
  assign count    = sp_q;
  assign dout     = dout_q;
  assign rd_valid = rd_valid_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= C_STACK;
    else     state_q <= state_d;
  end

  always_comb begin
    push_en    = 1'b0;
    sp_d       = sp_q;
    rd_ptr_d   = rd_ptr_q;
    dout_d     = dout_q;
    rd_valid_d = 1'b0;
    replay_req = (state_q == C_STACK) && rst_adr && !rst_adr_q;
    if (state_q == C_STACK) begin
      // a push shadows a same-cycle pop even when the push itself is dropped
      if (write) begin
        if (!full) begin
          push_en = 1'b1;
          sp_d    = sp_q + C_ONE;
        end
      end else if (read && !empty) begin
        dout_d     = mem_q[top_idx[ADDR_W-1:0]];
        sp_d       = top_idx;
        rd_valid_d = 1'b1;
      end
      if (replay_req) rd_ptr_d = '0;
    end else if (state_q == C_REPLAY && move_ready) begin
      rd_ptr_d = rd_ptr_q + C_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_STACK:  if (replay_req) state_d = (sp_d != '0) ? C_REPLAY : C_DONE;
      C_REPLAY: if (move_ready && (rd_ptr_q == top_idx)) state_d = C_DONE;
      C_DONE:   state_d = C_STACK;
      default:  state_d = C_STACK;
    endcase
  end

  always_comb begin
    move_valid = (state_q == C_REPLAY);
    finish     = (state_q == C_DONE);
    move_dir   = move_valid ? mem_q[rd_ptr_q[ADDR_W-1:0]] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q       <= '0;
      rd_ptr_q   <= '0;
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
      rst_adr_q  <= 1'b0;
    end else begin
      sp_q       <= sp_d;
      rd_ptr_q   <= rd_ptr_d;
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
      rst_adr_q  <= rst_adr;
    end
  end

  // storage is deliberately not reset; sp = 0 makes stale entries unreachable
  always_ff @(posedge clk) begin
    if (push_en && !rst) mem_q[sp_q[ADDR_W-1:0]] <= din;
  end

`ifdef PATH_STACK_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q
          | ((state_q == C_STACK) & ((write & full) | (read & empty) | (write & read)))
          | ((state_q == C_REPLAY) & (write | read));
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_path_stack.sv
`default_nettype none
// Randomized self-checking bench for path_stack (ADDR_W = 2) against a queue model.
module tb_path_stack;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic [1:0] din = 2'd0;
  logic [1:0] dout;
  logic       rd_valid;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       rst_adr = 1'b0;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       move_ready = 1'b0;
  logic       finish;
`ifdef PATH_STACK_ERR_EN
  logic       err;
`endif

  int vectors = 0;
  int miscompares = 0;

  int model_q[$];
  int got_q[$];
  int fin_idx, last_acc, fin_after;
  bit any_valid, timed_out;

  path_stack #(.DATA_W(2), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .write(write), .read(read), .din(din),
    .dout(dout), .rd_valid(rd_valid), .count(count), .full(full),
    .empty(empty), .rst_adr(rst_adr), .move_valid(move_valid),
    .move_dir(move_dir), .move_ready(move_ready), .finish(finish)
`ifdef PATH_STACK_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; write = 1'b0; read = 1'b0; rst_adr = 1'b0; move_ready = 1'b0;
    cycle();
    rst = 1'b0;
    model_q.delete();
  endtask

  task automatic push_val(input int v);
    write = 1'b1; din = v[1:0];
    cycle();
    write = 1'b0;
    if (model_q.size() < 4) model_q.push_back(v);
  endtask

  // mode 0: ready always, 1: ready on even cycles, 2: random ready
  task automatic run_replay(input int mode, input bit push_during);
    bit r;
    got_q.delete(); fin_idx = -1; last_acc = -1; any_valid = 0; timed_out = 0;
    rst_adr = 1'b1;
    cycle();
    rst_adr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (finish) begin fin_idx = i; break; end
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (i % 2 == 0) : 1'($urandom % 2);
      move_ready = r;
      if (push_during) begin write = 1'b1; din = 2'($urandom); end
      if (move_valid) any_valid = 1;
      if (move_valid && r) begin got_q.push_back(int'(move_dir)); last_acc = i; end
      cycle();
    end
    move_ready = 1'b0; write = 1'b0;
    if (fin_idx < 0) timed_out = 1;
    cycle();
    fin_after = int'(finish);
  endtask

  task automatic test_reset();
    rst = 1'b1; cycle(); cycle(); rst = 1'b0;
    model_q.delete();
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
    vectors++; if (empty !== 1'b1 || full !== 1'b0) begin miscompares++; $display("FAIL reset_flags: empty=%b full=%b want 1 0", empty, full); end
    vectors++; if (dout !== 2'd0 || rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_dout: dout=%0d rd_valid=%b want 0 0", dout, rd_valid); end
    vectors++; if (move_valid !== 1'b0 || move_dir !== 2'd0 || finish !== 1'b0) begin miscompares++; $display("FAIL reset_replay: mv=%b md=%0d fin=%b want 0 0 0", move_valid, move_dir, finish); end
`ifdef PATH_STACK_ERR_EN
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
`endif
  endtask

  task automatic test_push_pop();
    int exp;
    do_reset();
    push_val(1); push_val(2); push_val(3);
    vectors++; if (count !== 3'd3 || empty !== 1'b0) begin miscompares++; $display("FAIL pp_count: count=%0d empty=%b want 3 0", count, empty); end
    read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      exp = model_q.pop_back();
      vectors++; if (rd_valid !== 1'b1 || dout !== exp[1:0]) begin miscompares++; $display("FAIL pp_pop%0d: dout=%0d rd_valid=%b want %0d 1", i, dout, rd_valid, exp); end
    end
    read = 1'b0;
    cycle();
    vectors++; if (rd_valid !== 1'b0 || empty !== 1'b1) begin miscompares++; $display("FAIL pp_end: rd_valid=%b empty=%b want 0 1", rd_valid, empty); end
  endtask

  task automatic test_full();
    do_reset();
    write = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      din = 2'($urandom);
      cycle();
      vectors++; if (count !== 3'((i > 4) ? 4 : i) || full !== (i >= 4)) begin miscompares++; $display("FAIL full_push%0d: count=%0d full=%b want %0d %b", i, count, full, (i > 4) ? 4 : i, i >= 4); end
    end
    write = 1'b0;
`ifdef PATH_STACK_ERR_EN
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL full_err: got %b want 1", err); end
`endif
  endtask

  task automatic test_empty_and_simul();
    do_reset();
    read = 1'b1; cycle(); read = 1'b0;
    vectors++; if (rd_valid !== 1'b0 || count !== 3'd0) begin miscompares++; $display("FAIL underflow: rd_valid=%b count=%0d want 0 0", rd_valid, count); end
`ifdef PATH_STACK_ERR_EN
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL underflow_err: got %b want 1", err); end
`endif
    do_reset();
    push_val(1);
    write = 1'b1; read = 1'b1; din = 2'd2;
    cycle();
    write = 1'b0; read = 1'b0;
    model_q.push_back(2);
    vectors++; if (count !== 3'd2 || rd_valid !== 1'b0) begin miscompares++; $display("FAIL simul_wr_rd: count=%0d rd_valid=%b want 2 0", count, rd_valid); end
    read = 1'b1;
    cycle();
    vectors++; if (dout !== 2'd2 || rd_valid !== 1'b1) begin miscompares++; $display("FAIL simul_pop: dout=%0d rd_valid=%b want 2 1", dout, rd_valid); end
    read = 1'b0;
    cycle();
  endtask

  task automatic test_replay();
    do_reset();
    push_val(0); push_val(1); push_val(3);
    run_replay(0, 0);
    vectors++; if (timed_out || got_q.size() != 3) begin miscompares++; $display("FAIL replay_len: got %0d entries timeout=%b want 3", got_q.size(), timed_out); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] != model_q[i]) begin miscompares++; $display("FAIL replay_dir%0d: got %0d want %0d", i, got_q[i], model_q[i]); end
    end
    vectors++; if (last_acc != 2 || fin_idx != 3 || fin_after != 0) begin miscompares++; $display("FAIL replay_timing: last=%0d fin=%0d fin_after=%0d want 2 3 0", last_acc, fin_idx, fin_after); end
    vectors++; if (count !== 3'd3 || move_valid !== 1'b0) begin miscompares++; $display("FAIL replay_after: count=%0d mv=%b want 3 0", count, move_valid); end
    run_replay(0, 0);
    vectors++; if (got_q != model_q) begin miscompares++; $display("FAIL replay_again: got %0d entries want %0d", got_q.size(), model_q.size()); end
  endtask

  task automatic test_replay_empty();
    do_reset();
    run_replay(0, 0);
    vectors++; if (any_valid || fin_idx != 0 || fin_after != 0) begin miscompares++; $display("FAIL replay_empty: valid=%b fin=%0d fin_after=%0d want 0 0 0", any_valid, fin_idx, fin_after); end
  endtask

  task automatic test_replay_toggle();
    do_reset();
    for (int i = 0; i < 3; i++) push_val(int'($urandom % 4));
    run_replay(1, 1);
    vectors++; if (timed_out || got_q != model_q) begin miscompares++; $display("FAIL toggle_data: got %0d entries timeout=%b want %0d", got_q.size(), timed_out, model_q.size()); end
    vectors++; if (last_acc != 4 || fin_idx != 5) begin miscompares++; $display("FAIL toggle_timing: last=%0d fin=%0d want 4 5", last_acc, fin_idx); end
    vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL toggle_count: got %0d want 3", count); end
`ifdef PATH_STACK_ERR_EN
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL toggle_err: got %b want 1", err); end
`endif
  endtask

  task automatic test_rst_mid_replay();
    do_reset();
    push_val(2); push_val(1);
    rst_adr = 1'b1; cycle(); rst_adr = 1'b0;
    move_ready = 1'b1; cycle();
    rst = 1'b1; cycle(); rst = 1'b0; move_ready = 1'b0;
    model_q.delete();
    vectors++; if (move_valid !== 1'b0 || count !== 3'd0 || finish !== 1'b0) begin miscompares++; $display("FAIL rst_replay: mv=%b count=%0d fin=%b want 0 0 0", move_valid, count, finish); end
    push_val(3);
    vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL rst_replay_stack: count=%0d want 1", count); end
  endtask

  task automatic test_random();
    int exp_dout;
    bit exp_valid, w, r;
    int d;
    do_reset();
    exp_dout = 0;
    for (int n = 0; n < 400; n++) begin
      w = 1'($urandom % 2); r = 1'($urandom % 2); d = int'($urandom % 4);
      exp_valid = 0;
      if (w) begin
        if (model_q.size() < 4) model_q.push_back(d);
      end else if (r && model_q.size() > 0) begin
        exp_dout = model_q.pop_back();
        exp_valid = 1;
      end
      write = w; read = r; din = d[1:0];
      cycle();
      write = 1'b0; read = 1'b0;
      vectors++;
      if (rd_valid !== exp_valid || dout !== exp_dout[1:0] || count !== 3'(model_q.size())
          || full !== (model_q.size() == 4) || empty !== (model_q.size() == 0)) begin
        miscompares++;
        $display("FAIL rand_op%0d: rv=%b dout=%0d count=%0d full=%b empty=%b want %b %0d %0d", n, rd_valid, dout, count, full, empty, exp_valid, exp_dout, model_q.size());
      end
      if (n % 80 == 79) begin
        run_replay(2, 1'($urandom % 2));
        vectors++; if (timed_out || got_q != model_q || count !== 3'(model_q.size())) begin miscompares++; $display("FAIL rand_replay%0d: got %0d entries count=%0d timeout=%b want %0d", n, got_q.size(), count, timed_out, model_q.size()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_full();
    test_empty_and_simul();
    test_replay();
    test_replay_empty();
    test_replay_toggle();
    test_rst_mid_replay();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
